// File: rtl/alu_b_pkg.sv
// ---------------------------------------------------------------------------
// alu_b_pkg
//   Shared definitions for the ALU B-operand stage and its source mux.
//   - stage_state_t : occupancy state of the registered operand stage
//   - fsel_width()  : width of the fwd_sel code for a given source count
//   - idx_width()   : width of a forwarding-source index (0..NFWD-1)
//   - FSEL_NONE / FSEL_SRC_BASE : fwd_sel encoding; code k selects source k-1
// ---------------------------------------------------------------------------
package alu_b_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // fwd_sel encoding: 0 means "use RT", code k (1..NFWD) means source k-1.
  // Codes above NFWD are not errors; they fall back to RT.
  localparam int FSEL_NONE     = 0;
  localparam int FSEL_SRC_BASE = 1;

  function automatic int fsel_width(input int nfwd);
    return (nfwd < 1) ? 1 : $clog2(nfwd + 1);
  endfunction

  function automatic int idx_width(input int nfwd);
    return (nfwd < 2) ? 1 : $clog2(nfwd);
  endfunction

endpackage

// File: rtl/alu_b_src_mux.sv
// ---------------------------------------------------------------------------
// alu_b_src_mux
//   Combinational selection of the ALU B operand candidate.
//   Ports:
//     bsel      in   1 = take ext, 0 = RT / forwarded path
//     fwd_sel   in   0 = RT, k in 1..NFWD = forwarding source k-1, >NFWD = RT
//     rt, ext   in   register-file value and extended immediate
//     fwd_data  in   packed forwarded values, source i at [i*WIDTH +: WIDTH]
//     fwd_valid in   per-source "final data present" flags
//     operand   out  resolved operand (meaningful only when need_wait = 0)
//     need_wait out  selected forwarding source is not yet valid
//     wait_idx  out  index of the selected forwarding source
// ---------------------------------------------------------------------------
module alu_b_src_mux
  import alu_b_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NFWD   = 2,
  parameter int FSEL_W = fsel_width(NFWD),
  parameter int IDX_W  = idx_width(NFWD)
) (
  input  logic                  bsel,
  input  logic [FSEL_W-1:0]     fwd_sel,
  input  logic [WIDTH-1:0]      rt,
  input  logic [WIDTH-1:0]      ext,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  input  logic [NFWD-1:0]       fwd_valid,
  output logic [WIDTH-1:0]      operand,
  output logic                  need_wait,
  output logic [IDX_W-1:0]      wait_idx
);

  always_comb begin
    operand   = rt;
    need_wait = 1'b0;
    wait_idx  = '0;
    if (bsel) begin
      operand = ext;
    end else begin
      // At most one code matches; unmatched codes (0 or >NFWD) keep RT.
      for (int i = 0; i < NFWD; i++) begin
        if (int'(fwd_sel) == i + FSEL_SRC_BASE) begin
          wait_idx = IDX_W'(i);
          if (fwd_valid[i]) begin
            operand = fwd_data[i*WIDTH +: WIDTH];
          end else begin
            need_wait = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_b_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_b_operand_stage
//   Registers the ALU B operand (RT, EXT or a forwarded result) into the EX
//   stage behind a valid/ready handshake. When the selected forwarding source
//   is still pending (load-use), the stage parks in WAIT and captures the
//   source as soon as it becomes valid.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; valid never depends on ready, and an offered beat is held
//   (b_out stable while out_valid & !out_ready) until it is taken.
//
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     in_valid    upstream offers an operand request
//     in_ready    stage accepts this cycle: EMPTY, or FULL while out_ready
//     rt, ext     register-file value and extended immediate
//     bsel        1 = ext, 0 = RT / forwarded path
//     fwd_sel     0 = RT, k = forwarding source k-1, >NFWD = RT
//     fwd_data    packed forwarded values, source i at [i*WIDTH +: WIDTH]
//     fwd_valid   per-source final-data flags
//     flush       discard the held/pending operand and any simultaneous accept
//     out_valid   b_out holds an operand for the ALU
//     out_ready   ALU takes b_out this cycle
//     b_out       registered B operand
//     fwd_wait    stage is waiting on a forwarding source
//     wait_cnt    saturating count of WAIT cycles since reset
//     dbg_state   current stage state (stage_state_t encoding)
// ---------------------------------------------------------------------------
module alu_b_operand_stage
  import alu_b_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NFWD   = 2,
  parameter  int CNT_W  = 16,
  localparam int FSEL_W = fsel_width(NFWD)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      rt,
  input  logic [WIDTH-1:0]      ext,
  input  logic                  bsel,
  input  logic [FSEL_W-1:0]     fwd_sel,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      b_out,
  output logic                  fwd_wait,
  output logic [CNT_W-1:0]      wait_cnt,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = idx_width(NFWD);

  stage_state_t     state, state_n;
  logic [IDX_W-1:0] wait_idx_q, wait_idx_n;
  logic [WIDTH-1:0] load_val;
  logic             load;

  logic             accept;
  logic [WIDTH-1:0] mux_operand;
  logic             mux_need_wait;
  logic [IDX_W-1:0] mux_wait_idx;
  logic             wait_src_valid;
  logic [WIDTH-1:0] wait_src_data;

  alu_b_src_mux #(
    .WIDTH  (WIDTH),
    .NFWD   (NFWD),
    .FSEL_W (FSEL_W),
    .IDX_W  (IDX_W)
  ) u_src_mux (
    .bsel      (bsel),
    .fwd_sel   (fwd_sel),
    .rt        (rt),
    .ext       (ext),
    .fwd_data  (fwd_data),
    .fwd_valid (fwd_valid),
    .operand   (mux_operand),
    .need_wait (mux_need_wait),
    .wait_idx  (mux_wait_idx)
  );

  // Outputs derived from registered state only; fwd_valid never reaches
  // fwd_wait or out_valid combinationally.
  assign in_ready  = (state == ST_EMPTY) || ((state == ST_FULL) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_FULL);
  assign fwd_wait  = (state == ST_WAIT);
  assign dbg_state = state;

  // Source being waited on, selected by the latched index.
  always_comb begin
    wait_src_valid = 1'b0;
    wait_src_data  = '0;
    for (int i = 0; i < NFWD; i++) begin
      if (wait_idx_q == IDX_W'(i)) begin
        wait_src_valid = fwd_valid[i];
        wait_src_data  = fwd_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_n    = state;
    wait_idx_n = wait_idx_q;
    load       = 1'b0;
    load_val   = mux_operand;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          if (mux_need_wait) begin
            state_n    = ST_WAIT;
            wait_idx_n = mux_wait_idx;
          end else begin
            state_n = ST_FULL;
            load    = 1'b1;
          end
        end
      end
      ST_FULL: begin
        // Reloading in the same cycle the ALU consumes keeps 1 op/cycle.
        if (out_ready) begin
          if (accept) begin
            if (mux_need_wait) begin
              state_n    = ST_WAIT;
              wait_idx_n = mux_wait_idx;
            end else begin
              load = 1'b1;
            end
          end else begin
            state_n = ST_EMPTY;
          end
        end
      end
      ST_WAIT: begin
        if (wait_src_valid) begin
          state_n  = ST_FULL;
          load     = 1'b1;
          load_val = wait_src_data;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    // Flush overrides everything except reset; b_out is left untouched.
    if (flush) begin
      state_n = ST_EMPTY;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      wait_idx_q <= '0;
      b_out      <= '0;
    end else begin
      state      <= state_n;
      wait_idx_q <= wait_idx_n;
      if (load) begin
        b_out <= load_val;
      end
    end
  end

  // Counts every cycle spent in WAIT, including a cycle that ends in flush;
  // flush does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((state == ST_WAIT) && (wait_cnt != {CNT_W{1'b1}})) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_b_operand_stage.sv
module tb_alu_b_operand_stage;

  localparam int WIDTH   = 32;
  localparam int NFWD    = 2;
  localparam int CNT_W   = 4;
  localparam int FSEL_W  = $clog2(NFWD + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      rt;
  logic [WIDTH-1:0]      ext;
  logic                  bsel;
  logic [FSEL_W-1:0]     fwd_sel;
  logic [NFWD*WIDTH-1:0] fwd_data;
  logic [NFWD-1:0]       fwd_valid;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      b_out;
  logic                  fwd_wait;
  logic [CNT_W-1:0]      wait_cnt;
  logic [1:0]            dbg_state;

  alu_b_operand_stage #(
    .WIDTH (WIDTH),
    .NFWD  (NFWD),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rt        (rt),
    .ext       (ext),
    .bsel      (bsel),
    .fwd_sel   (fwd_sel),
    .fwd_data  (fwd_data),
    .fwd_valid (fwd_valid),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b_out     (b_out),
    .fwd_wait  (fwd_wait),
    .wait_cnt  (wait_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit mon_en  = 1'b0;
  bit rand_en = 1'b0;
  bit flush_en = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: the stage either holds a resolved operand (m_full),
  // is owed one by forwarding source m_src (m_waiting), or holds nothing.
  bit m_full    = 1'b0;
  bit m_waiting = 1'b0;
  int m_src     = 0;
  int m_cnt     = 0;

  typedef struct {
    bit               full;
    bit               waiting;
    int               src;
    int               cnt;
    bit               push;
    logic [WIDTH-1:0] pval;
    bit               clear;
  } mstep_t;

  function automatic logic [WIDTH-1:0] src_word(input int k);
    return fwd_data[k*WIDTH +: WIDTH];
  endfunction

  function automatic mstep_t model_step();
    mstep_t r;
    bit     take;
    r.full = m_full; r.waiting = m_waiting; r.src = m_src; r.cnt = m_cnt;
    r.push = 1'b0; r.pval = '0; r.clear = 1'b0;
    if (reset) begin
      r.full = 1'b0; r.waiting = 1'b0; r.cnt = 0; r.clear = 1'b1;
      return r;
    end
    if (m_waiting) r.cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    if (flush) begin
      r.full = 1'b0; r.waiting = 1'b0; r.clear = 1'b1;
      return r;
    end
    if (m_waiting) begin
      if (fwd_valid[m_src]) begin
        r.waiting = 1'b0; r.full = 1'b1; r.push = 1'b1; r.pval = src_word(m_src);
      end
      return r;
    end
    take = in_valid && (!m_full || out_ready);
    if (m_full && out_ready) r.full = 1'b0;
    if (take) begin
      if (bsel) begin
        r.full = 1'b1; r.push = 1'b1; r.pval = ext;
      end else if (int'(fwd_sel) == 0 || int'(fwd_sel) > NFWD) begin
        r.full = 1'b1; r.push = 1'b1; r.pval = rt;
      end else begin
        r.src = int'(fwd_sel) - 1;
        if (fwd_valid[r.src]) begin
          r.full = 1'b1; r.push = 1'b1; r.pval = src_word(r.src);
        end else begin
          r.waiting = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    mstep_t r;
    r = model_step();
    if (r.clear) exp_q.delete();
    if (r.push) exp_q.push_back(r.pval);
    m_full    <= r.full;
    m_waiting <= r.waiting;
    m_src     <= r.src;
    m_cnt     <= r.cnt;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", WIDTH'(in_ready), WIDTH'((!m_full && !m_waiting) || (m_full && out_ready)));
      check("out_valid", WIDTH'(out_valid), WIDTH'(m_full));
      check("fwd_wait", WIDTH'(fwd_wait), WIDTH'(m_waiting));
      check("wait_cnt", WIDTH'(wait_cnt), WIDTH'(m_cnt));
      if (m_full) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL b_out: got %h expected nothing queued at %0t", b_out, $time);
        end else begin
          check("b_out", b_out, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_en) begin
      out_ready = ($urandom_range(0, 3) != 0);
      fwd_valid = NFWD'($urandom);
      fwd_data  = {$urandom, $urandom};
      flush     = flush_en && ($urandom_range(0, 24) == 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  // Offer one request and hold it until the stage takes it (bounded).
  task automatic issue(input logic b, input logic [FSEL_W-1:0] fs,
                       input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] e);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; bsel = b; fwd_sel = fs; rt = r; ext = e;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      cycle();
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got in_ready=0 for 300 cycles expected accept at %0t", $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; bsel = 1'b0; fwd_sel = '0; rt = '0; ext = '0;
    fwd_data = '0; fwd_valid = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_out_valid", WIDTH'(out_valid), '0);
    check("rst_b_out", b_out, '0);
    check("rst_fwd_wait", WIDTH'(fwd_wait), '0);
    check("rst_wait_cnt", WIDTH'(wait_cnt), '0);
    check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));

    // EXT select
    out_ready = 1'b1;
    issue(1'b1, '0, 32'h0000_0055, 32'hFFFF_FFF0);
    @(negedge clk);
    check("ext_out_valid", WIDTH'(out_valid), WIDTH'(1));
    check("ext_b_out", b_out, 32'hFFFF_FFF0);

    // Forward hit on the youngest source
    fwd_valid = 2'b01;
    fwd_data  = {32'h0BAD_0BAD, 32'h1234_5678};
    issue(1'b0, FSEL_W'(1), 32'h0000_0077, 32'h0000_0099);
    @(negedge clk);
    check("fwd_hit_out_valid", WIDTH'(out_valid), WIDTH'(1));
    check("fwd_hit_b_out", b_out, 32'h1234_5678);

    // Load-use: source 1 pending, becomes valid in the third WAIT-side cycle
    do_reset();
    fwd_valid = 2'b00;
    fwd_data  = {32'hDEAD_BEEF, 32'h0000_0001};
    out_ready = 1'b1;
    issue(1'b0, FSEL_W'(2), 32'h1111_1111, 32'h2222_2222);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) fwd_valid = 2'b10;
      @(negedge clk);
      check("lu_fwd_wait", WIDTH'(fwd_wait), WIDTH'(1));
      check("lu_in_ready", WIDTH'(in_ready), '0);
      cycle();
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("lu_out_valid", WIDTH'(out_valid), WIDTH'(1));
    check("lu_b_out", b_out, 32'hDEAD_BEEF);
    check("lu_wait_cnt", WIDTH'(wait_cnt), WIDTH'(3));

    // Back-pressure: new request waits while the ALU stalls
    in_valid = 1'b1; bsel = 1'b1; ext = 32'hA5A5_0001;
    for (int i = 0; i < 4; i++) begin
      cycle();
      @(negedge clk);
      check("bp_b_out_held", b_out, 32'hDEAD_BEEF);
      check("bp_in_ready", WIDTH'(in_ready), '0);
    end
    cycle();
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_reload_valid", WIDTH'(out_valid), WIDTH'(1));
    check("bp_reload_b_out", b_out, 32'hA5A5_0001);
    repeat (2) cycle();

    // Flush in WAIT with a simultaneous request
    do_reset();
    fwd_valid = 2'b00;
    issue(1'b0, FSEL_W'(1), 32'h3333_3333, 32'h4444_4444);
    cycle();
    flush = 1'b1; in_valid = 1'b1; bsel = 1'b1; ext = 32'h5555_5555;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", WIDTH'(out_valid), '0);
    check("flush_in_ready", WIDTH'(in_ready), WIDTH'(1));
    check("flush_fwd_wait", WIDTH'(fwd_wait), '0);
    check("flush_wait_cnt", WIDTH'(wait_cnt), WIDTH'(2));
    cycle();
    @(negedge clk);
    check("flush_dropped", WIDTH'(out_valid), '0);

    // Counter saturation, then reset from WAIT
    do_reset();
    fwd_valid = 2'b00;
    issue(1'b0, FSEL_W'(2), 32'h6666_6666, 32'h7777_7777);
    repeat (20) cycle();
    @(negedge clk);
    check("sat_wait_cnt", WIDTH'(wait_cnt), WIDTH'(15));
    check("sat_fwd_wait", WIDTH'(fwd_wait), WIDTH'(1));
    do_reset();
    @(negedge clk);
    check("rst2_out_valid", WIDTH'(out_valid), '0);
    check("rst2_b_out", b_out, '0);
    check("rst2_fwd_wait", WIDTH'(fwd_wait), '0);
    check("rst2_wait_cnt", WIDTH'(wait_cnt), '0);

    // Randomized traffic with back-pressure, pending sources and flushes
    rand_en  = 1'b1;
    flush_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) cycle();
      issue(($urandom_range(0, 3) == 0), FSEL_W'($urandom_range(0, 3)), $urandom, $urandom);
    end

    // Drain
    rand_en = 1'b0; flush = 1'b0; fwd_valid = '1; out_ready = 1'b1;
    repeat (6) cycle();
    @(negedge clk);
    check("drain_queue_empty", WIDTH'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
